// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-port arbiter: default widths, FSM
// state encoding and the next-state rule.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFRd  = 2'd1,
    StDRd  = 2'd2
  } arb_state_e;

  // A store leaves nothing in flight, so it returns to idle like a non-grant.
  function automatic arb_state_e arb_next_state(logic f_gnt, logic d_gnt, logic d_we);
    if (f_gnt) begin
      return StFRd;
    end
    if (d_gnt && !d_we) begin
      return StDRd;
    end
    return StIdle;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, load/store port and RAM command bundle for mem_port_arbiter.
// The arbiter is the slave; CPU plus RAM (or a bench) sit on the master side.
interface mem_port_arbiter_if
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, and under
// contention the side that did not win last time is chosen.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,  // 1 = requester 1 won most recently
  output logic gnt0,
  output logic gnt1
);

  assign gnt0 = req0 & (~req1 | last);
  assign gnt1 = req1 & (~req0 | ~last);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store, one
// command per cycle, with the 1-cycle read response tracked by a small FSM.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  arb_state_e        state_q;
  logic              last_d_q;
  logic              f_pick, d_pick;
  logic              f_gnt, d_gnt;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  rr_pick2 u_rr_pick2 (
    .req0 (bus.f_req),
    .req1 (bus.d_req),
    .last (last_d_q),
    .gnt0 (f_pick),
    .gnt1 (d_pick)
  );

  // Reset is synchronous, so outputs are masked directly while it is high.
  assign f_gnt = f_pick & ~reset;
  assign d_gnt = d_pick & ~reset;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_en   = 1'b1;
      mem_addr = bus.f_addr;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = bus.d_we;
      mem_addr  = bus.d_addr;
      mem_wdata = bus.d_wdata;
    end
  end

  // Fetch counts as the last winner out of reset, so data takes the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      last_d_q <= 1'b0;
    end else begin
      state_q <= arb_next_state(f_gnt, d_gnt, bus.d_we);
      if (f_gnt || d_gnt) begin
        last_d_q <= d_gnt;
      end
    end
  end

  assign bus.f_gnt     = f_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  assign bus.f_rvalid  = (state_q == StFRd) & ~reset;
  assign bus.d_rvalid  = (state_q == StDRd) & ~reset;
  assign bus.f_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

  gnt_onehot_a : assert property (@(posedge clk) !(f_gnt && d_gnt));
  reset_quiet_a : assert property (@(posedge clk) reset |-> !(mem_en || mem_we));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural RAM, a per-cycle
// reference model of grants and responses, and directed literal checks.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 10'd5) ? 16'h1234 : (16'hA000 | 16'(a));
  endfunction

  // Behavioural RAM: unwritten words read their init pattern.
  logic [DW-1:0] ram [DEPTH];
  bit            ram_wr [DEPTH];

  function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
    return ram_wr[a] ? ram[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr]    <= bus.mem_wdata;
        ram_wr[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= ram_rd(bus.mem_addr);
      end
    end
  end

  // Reference model: who owns the next contention, what read is in flight,
  // and a shadow memory updated by the stores the model itself predicts.
  logic [DW-1:0] sh [DEPTH];
  bit            sh_wr [DEPTH];
  bit            data_next = 1'b1;
  int            pend_kind = 0;  // 0 none, 1 fetch, 2 load
  logic [DW-1:0] pend_val = '0;
  bit            n_data_next = 1'b1;
  int            n_pend = 0;
  logic [DW-1:0] n_val = '0;
  bit            n_sh_we = 1'b0;
  logic [AW-1:0] n_sh_a = '0;
  logic [DW-1:0] n_sh_d = '0;
  bit            efg, edg, efv, edv;

  function automatic logic [DW-1:0] sh_rd(input logic [AW-1:0] a);
    return sh_wr[a] ? sh[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      efg = 1'b0;
      edg = 1'b0;
    end else begin
      edg = bus.d_req && (!bus.f_req || data_next);
      efg = bus.f_req && !edg;
    end
    efv = !reset && (pend_kind == 1);
    edv = !reset && (pend_kind == 2);

    check("f_gnt", 32'(bus.f_gnt), 32'(efg));
    check("d_gnt", 32'(bus.d_gnt), 32'(edg));
    check("mem_en", 32'(bus.mem_en), 32'(efg || edg));
    check("mem_we", 32'(bus.mem_we), 32'(edg && bus.d_we));
    if (efg) begin
      check("mem_addr_f", 32'(bus.mem_addr), 32'(bus.f_addr));
    end else if (edg) begin
      check("mem_addr_d", 32'(bus.mem_addr), 32'(bus.d_addr));
      if (bus.d_we) check("mem_wdata", 32'(bus.mem_wdata), 32'(bus.d_wdata));
    end
    check("f_rvalid", 32'(bus.f_rvalid), 32'(efv));
    check("d_rvalid", 32'(bus.d_rvalid), 32'(edv));
    if (efv) check("f_rdata", 32'(bus.f_rdata), 32'(pend_val));
    if (edv) check("d_rdata", 32'(bus.d_rdata), 32'(pend_val));

    n_pend      <= efg ? 1 : ((edg && !bus.d_we) ? 2 : 0);
    n_val       <= efg ? sh_rd(bus.f_addr) : sh_rd(bus.d_addr);
    n_data_next <= reset ? 1'b1 : (efg ? 1'b1 : (edg ? 1'b0 : data_next));
    n_sh_we     <= edg && bus.d_we;
    n_sh_a      <= bus.d_addr;
    n_sh_d      <= bus.d_wdata;
  end

  always @(posedge clk) begin
    pend_kind <= n_pend;
    pend_val  <= n_val;
    data_next <= n_data_next;
    if (n_sh_we) begin
      sh[n_sh_a]    <= n_sh_d;
      sh_wr[n_sh_a] <= 1'b1;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    bus.f_req   = 1'b1;
    bus.f_addr  = '0;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    reset       = 1'b1;

    // Requests during reset are ignored.
    sample();
    check("rst_f_gnt", 32'(bus.f_gnt), 32'd0);
    check("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    next_cycle();
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    reset     = 1'b0;
    sample();

    // Single fetch of 0x005.
    next_cycle();
    bus.f_req  = 1'b1;
    bus.f_addr = 10'h005;
    sample();
    check("fetch_gnt", 32'(bus.f_gnt), 32'd1);
    check("fetch_addr", 32'(bus.mem_addr), 32'h005);
    next_cycle();
    bus.f_req = 1'b0;
    sample();
    check("fetch_rvalid", 32'(bus.f_rvalid), 32'd1);
    check("fetch_rdata", 32'(bus.f_rdata), 32'h1234);

    // Store 0xBEEF to 0x010, then fetch it back.
    next_cycle();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 10'h010;
    bus.d_wdata = 16'hBEEF;
    sample();
    check("store_gnt", 32'(bus.d_gnt), 32'd1);
    check("store_we", 32'(bus.mem_we), 32'd1);
    next_cycle();
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    sample();
    check("store_no_rvalid", 32'(bus.d_rvalid), 32'd0);
    next_cycle();
    bus.f_req  = 1'b1;
    bus.f_addr = 10'h010;
    sample();
    next_cycle();
    bus.f_req = 1'b0;
    sample();
    check("store_readback", 32'(bus.f_rdata), 32'hBEEF);

    // Contention after reset: D, F, D, F.
    next_cycle();
    reset = 1'b1;
    sample();
    next_cycle();
    reset      = 1'b0;
    bus.f_req  = 1'b1;
    bus.d_req  = 1'b1;
    bus.f_addr = 10'h001;
    bus.d_addr = 10'h002;
    for (int k = 0; k < 4; k++) begin
      sample();
      check($sformatf("rr_d_gnt%0d", k), 32'(bus.d_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_f_gnt%0d", k), 32'(bus.f_gnt), (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k % 2 == 1) check($sformatf("rr_d_rdata%0d", k), 32'(bus.d_rdata), 32'hA002);
      next_cycle();
    end
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    sample();
    check("rr_last_f_rvalid", 32'(bus.f_rvalid), 32'd1);
    check("rr_last_f_rdata", 32'(bus.f_rdata), 32'hA001);

    // Back-to-back fetches 0x000..0x003.
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      bus.f_req  = 1'b1;
      bus.f_addr = 10'(k);
      sample();
      check($sformatf("b2b_gnt%0d", k), 32'(bus.f_gnt), 32'd1);
      if (k > 0) check($sformatf("b2b_rdata%0d", k), 32'(bus.f_rdata), 32'hA000 | 32'(k - 1));
      next_cycle();
    end
    bus.f_req = 1'b0;
    sample();
    check("b2b_last_rvalid", 32'(bus.f_rvalid), 32'd1);
    check("b2b_last_rdata", 32'(bus.f_rdata), 32'hA003);

    // Reset right after a load grant drops the response and restores data priority.
    next_cycle();
    bus.d_req  = 1'b1;
    bus.d_addr = 10'h003;
    sample();
    check("rst_load_gnt", 32'(bus.d_gnt), 32'd1);
    next_cycle();
    bus.d_req = 1'b0;
    reset     = 1'b1;
    sample();
    check("rst_load_rvalid0", 32'(bus.d_rvalid), 32'd0);
    next_cycle();
    reset = 1'b0;
    sample();
    check("rst_load_rvalid1", 32'(bus.d_rvalid), 32'd0);
    next_cycle();
    bus.f_req  = 1'b1;
    bus.d_req  = 1'b1;
    bus.f_addr = 10'h004;
    sample();
    check("post_rst_d_wins", 32'(bus.d_gnt), 32'd1);
    check("post_rst_f_waits", 32'(bus.f_gnt), 32'd0);
    next_cycle();
    sample();
    check("post_rst_f_next", 32'(bus.f_gnt), 32'd1);

    // Store wins contention; fetch of the same word follows it.
    next_cycle();
    bus.d_we    = 1'b1;
    bus.d_addr  = 10'h005;
    bus.d_wdata = 16'h5555;
    sample();
    check("cont_store_we", 32'(bus.mem_we), 32'd1);
    next_cycle();
    bus.d_req  = 1'b0;
    bus.d_we   = 1'b0;
    bus.f_addr = 10'h005;
    sample();
    check("cont_fetch_gnt", 32'(bus.f_gnt), 32'd1);
    next_cycle();
    bus.f_req = 1'b0;
    sample();
    check("cont_fetch_rdata", 32'(bus.f_rdata), 32'h5555);

    repeat (3) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
